rf_arbiter: RTL

Shares the 4×8-bit register file's single write port and two read ports between two requesters: port 0 (core execute stage) and port 1 (debug/loader path). Requests use a valid/ready handshake with round-robin arbitration. The granted request goes through a one-stage issue register that drives the register file's write-enable, address and data inputs. Each requester receives a one-cycle response pulse carrying read data or a write acknowledge.

---
 rtl/rf_arbiter_pkg.sv | 28 ++
 rtl/rf_arbiter_rr_arb2.sv | 41 ++++
 rtl/rf_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_arbiter_pkg.sv
// ============================================================================
// Module      : rf_arbiter_pkg
// Description : Shared definitions for the register-file arbiter: default
//               data/address widths, the lock FSM state encoding and the
//               requester port indices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_arbiter_pkg;

   localparam int DW_DEF       = 8;   // register / data width
   localparam int AW_DEF       = 2;   // register address width (4 registers)
   localparam int LOCK_MAX_DEF = 8;   // max consecutive grants under a lock

   // Lock FSM: normal round-robin, or port 1 owns the arbiter.
   typedef enum logic [0:0] {
      ARB_RR    = 1'b0,
      ARB_LOCK1 = 1'b1
   } arb_state_e;

   // Requester indices.
   localparam logic PORT_CORE = 1'b0;   // core execute stage
   localparam logic PORT_DBG  = 1'b1;   // debug / loader path

endpackage

`default_nettype wire

// File: rtl/rf_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rf_arbiter_rr_arb2
// Description : Combinational two-way round-robin grant. Under a lock only
//               the debug port can be granted.
// Ports       : valid_i [1:0] - request present per port
//               last_i        - port granted most recently
//               lock_i        - debug port owns the arbiter
//               grant_o [1:0] - one-hot (or zero) grant
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_arbiter_rr_arb2
   import rf_arbiter_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       last_i,
   input  logic       lock_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = 2'b00;
      if (lock_i) begin
         grant_o[PORT_DBG] = valid_i[PORT_DBG];
      end else if (valid_i[PORT_CORE] && valid_i[PORT_DBG]) begin
         // Tie: whichever port did not win last time goes next.
         if (last_i == PORT_DBG) begin
            grant_o[PORT_CORE] = 1'b1;
         end else begin
            grant_o[PORT_DBG] = 1'b1;
         end
      end else begin
         // A lone requester is granted immediately.
         grant_o = valid_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rf_arbiter.sv
// ============================================================================
// Module      : rf_arbiter
// Description : Shares a 4x8 register file (one write port, two combinational
//               read ports) between the core (port 0) and the debug/loader
//               path (port 1). Valid/ready request handshake, round-robin
//               grant, one issue register driving the register file, and a
//               one-cycle response pulse two cycles after acceptance.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               req_valid_i/req_ready_o    - per-port request handshake
//               req_we_i, req_rd_i,
//               req_rs_i, req_wdata_i      - per-port request fields
//               req_lock_i                 - port 1 grant lock (port 0 tied 0)
//               rsp_valid_o, rsp_a_o,
//               rsp_b_o                    - per-port response
//               rf_we, rf_rd, rf_rs, rf_din - to the register file
//               rf_a, rf_b                 - register file read data
// Config      : RF_ARB_LOCK_EN - compiles in the port-1 lock FSM and counter.
//               When undefined, req_lock_i is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_arbiter
   import rf_arbiter_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int LOCK_MAX = LOCK_MAX_DEF
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           req_valid_i,
   output logic [1:0]           req_ready_o,
   input  logic [1:0]           req_we_i,
   input  logic [1:0][AW-1:0]   req_rd_i,
   input  logic [1:0][AW-1:0]   req_rs_i,
   input  logic [1:0][DW-1:0]   req_wdata_i,
   input  logic [1:0]           req_lock_i,
   output logic [1:0]           rsp_valid_o,
   output logic [1:0][DW-1:0]   rsp_a_o,
   output logic [1:0][DW-1:0]   rsp_b_o,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_rd,
   output logic [AW-1:0]        rf_rs,
   output logic [DW-1:0]        rf_din,
   input  logic [DW-1:0]        rf_a,
   input  logic [DW-1:0]        rf_b
);

   logic [1:0]          w_grant;
   logic                w_lock_hold;
   logic                w_acc;
   logic                w_acc_port;
   logic                w_unused;

   logic                last_q, last_d;

   logic                iss_valid_q;
   logic                iss_port_q;
   logic                iss_we_q;
   logic [AW-1:0]       iss_rd_q;
   logic [AW-1:0]       iss_rs_q;
   logic [DW-1:0]       iss_wdata_q;

   logic [1:0]          rsp_valid_q;
   logic [1:0][DW-1:0]  rsp_a_q;
   logic [1:0][DW-1:0]  rsp_b_q;

   // ------------------------------------------------------------------------
   // Arbitration (combinational in the accept cycle)
   // ------------------------------------------------------------------------
   rf_arbiter_rr_arb2 u_rr_arb2 (
      .valid_i (req_valid_i),
      .last_i  (last_q),
      .lock_i  (w_lock_hold),
      .grant_o (w_grant)
   );

   // Ready is held low while reset is asserted so nothing is accepted.
   assign req_ready_o = w_grant & {2{rst_n}};
   assign w_acc       = |(req_valid_i & req_ready_o);
   assign w_acc_port  = req_ready_o[PORT_DBG];

   always_comb begin
      last_d = last_q;
      if (w_acc) begin
         last_d = w_acc_port;
      end
   end

   // ------------------------------------------------------------------------
   // Optional port-1 lock
   // ------------------------------------------------------------------------
`ifdef RF_ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   arb_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_RR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q counts the grants still owed to port 1; the grant that brings it
   // to zero is the last one before the lock is forcibly released.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ARB_RR: begin
            if (w_acc && (w_acc_port == PORT_DBG) && req_lock_i[PORT_DBG]
                && (LOCK_MAX > 1)) begin
               state_d = ARB_LOCK1;
               cnt_d   = CNT_W'(LOCK_MAX - 1);
            end
         end
         ARB_LOCK1: begin
            // Only port 1 can be accepted here.
            if (w_acc) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (!req_lock_i[PORT_DBG] || (cnt_q == CNT_W'(1))) begin
                  state_d = ARB_RR;
               end
            end
         end
         default: begin
            state_d = ARB_RR;
         end
      endcase
   end

   assign w_lock_hold = (state_q == ARB_LOCK1);
   assign w_unused    = req_lock_i[PORT_CORE];
`else
   assign w_lock_hold = 1'b0;
   assign w_unused    = (^req_lock_i) ^ (LOCK_MAX > 0);
`endif

   // ------------------------------------------------------------------------
   // Round-robin pointer and issue stage
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q      <= PORT_DBG;
         iss_valid_q <= 1'b0;
         iss_port_q  <= PORT_CORE;
         iss_we_q    <= 1'b0;
         iss_rd_q    <= '0;
         iss_rs_q    <= '0;
         iss_wdata_q <= '0;
      end else begin
         last_q      <= last_d;
         iss_valid_q <= w_acc;
         // Fields load only on acceptance so the register-file address and
         // data hold their last values while idle.
         if (w_acc) begin
            iss_port_q  <= w_acc_port;
            iss_we_q    <= req_we_i[w_acc_port];
            iss_rd_q    <= req_rd_i[w_acc_port];
            iss_rs_q    <= req_rs_i[w_acc_port];
            iss_wdata_q <= req_wdata_i[w_acc_port];
         end
      end
   end

   // Reset clears iss_valid_q asynchronously, so an in-flight write is
   // dropped before the next clock edge.
   assign rf_we  = iss_valid_q & iss_we_q;
   assign rf_rd  = iss_rd_q;
   assign rf_rs  = iss_rs_q;
   assign rf_din = iss_wdata_q;

   // ------------------------------------------------------------------------
   // Response: read data captured at the end of the issue cycle, so a write
   // returns the pre-write value of R[rd].
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= '0;
         rsp_a_q     <= '0;
         rsp_b_q     <= '0;
      end else begin
         rsp_valid_q <= 2'b00;
         if (iss_valid_q) begin
            rsp_valid_q[iss_port_q] <= 1'b1;
            rsp_a_q[iss_port_q]     <= rf_a;
            rsp_b_q[iss_port_q]     <= rf_b;
         end
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_a_o     = rsp_a_q;
   assign rsp_b_o     = rsp_b_q;

endmodule

`default_nettype wire
